// File: rtl/pattern_scan_ctrl.sv
// Two-requester word scanner: round-robin grants a word, shifts it out MSB-first
// through a non-overlapping Mealy "1010" detector, then reports the match count.
module pattern_scan_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] din0,
    input  logic             req1,
    input  logic [WIDTH-1:0] din1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             ser_bit,
    output logic             done,
    output logic             done_id,
    output logic [CNT_W-1:0] match_cnt
);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_t;
    typedef enum logic [1:0] {S0, S1, S2, S3} det_t;

    state_t           state_reg;
    det_t             det_reg;
    det_t             det_next;
    logic             hit;
    logic [WIDTH-1:0] shift_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             id_reg;
    logic             last_reg;     // requester served most recently
    logic             pick1;
    logic             grant_any;
    logic             cur_bit;

    assign cur_bit = shift_reg[WIDTH-1];

    // Round-robin choice: requester 1 wins only if alone or if 0 was served last.
    assign pick1     = req1 & (~req0 | ~last_reg);
    assign grant_any = (state_reg == IDLE) & ~reset & (req0 | req1);
    assign gnt1      = grant_any & pick1;
    assign gnt0      = grant_any & ~pick1;

    // Mealy 1010 detector transition; a match sends it back to S0 (no overlap).
    always_comb begin
        det_next = S0;
        hit      = 1'b0;
        case (det_reg)
            S0: det_next = cur_bit ? S1 : S0;
            S1: det_next = cur_bit ? S1 : S2;
            S2: det_next = cur_bit ? S3 : S0;
            S3: begin
                det_next = cur_bit ? S1 : S0;
                hit      = ~cur_bit;
            end
            default: det_next = S0;
        endcase
    end

    // Controller FSM with capture register, bit index, detector and match counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            det_reg   <= S0;
            shift_reg <= '0;
            idx_reg   <= IDX_TOP;
            cnt_reg   <= '0;
            id_reg    <= 1'b0;
            last_reg  <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req0 | req1) begin
                        shift_reg <= pick1 ? din1 : din0;
                        idx_reg   <= IDX_TOP;
                        cnt_reg   <= '0;
                        det_reg   <= S0;
                        id_reg    <= pick1;
                        last_reg  <= pick1;
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
                    det_reg   <= det_next;
                    if (hit && cnt_reg != CNT_MAX)
                        cnt_reg <= cnt_reg + 1'b1;
                    idx_reg <= idx_reg - 1'b1;
                    if (idx_reg == '0)
                        state_reg <= REPORT;
                end
                REPORT: begin
                    det_reg   <= S0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Status outputs decode the registered state; all forced low while reset is high.
    assign busy      = ~reset & (state_reg != IDLE);
    assign ser_bit   = ~reset & (state_reg == SHIFT) & cur_bit;
    assign done      = ~reset & (state_reg == REPORT);
    assign done_id   = ~reset & id_reg;
    assign match_cnt = reset ? '0 : cnt_reg;

endmodule

// File: doc/pattern_scan_ctrl.md
PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: bits per scanned word, minimum 4.
REQ-002 Parameter CNT_W, default 4: width of match count.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0  input  1  requester 0 word request; held high until granted.
REQ-006 din0  input  WIDTH  requester 0 word; held stable while req0 high.
REQ-007 req1  input  1  requester 1 word request; held high until granted.
REQ-008 din1  input  WIDTH  requester 1 word; held stable while req1 high.
REQ-009 gnt0  output  1  one-cycle grant to requester 0; din0 captured on that edge.
REQ-010 gnt1  output  1  one-cycle grant to requester 1; din1 captured on that edge.
REQ-011 busy  output  1  high in SHIFT and REPORT.
REQ-012 ser_bit  output  1  bit presented to detector this cycle, 0 outside SHIFT.
REQ-013 done  output  1  one-cycle pulse, result valid.
REQ-014 done_id  output  1  requester served by current result.
REQ-015 match_cnt  output  CNT_W  count of pattern matches in scanned word.

Function
REQ-016 Controller FSM SHALL have states IDLE, SHIFT, REPORT.
REQ-017 IDLE: if any req, SHALL assert exactly one gnt combinationally, capture selected din into shift register, clear bit index to WIDTH-1, clear match count, reset detector to S0, go SHIFT; no req stays IDLE.
REQ-018 Arbitration SHALL be round-robin: single req granted directly; both req -> requester not served last; after reset, requester 0 wins a tie.
REQ-019 gnt0/gnt1 SHALL be low outside IDLE; requests arriving in SHIFT/REPORT wait.
REQ-020 SHIFT: SHALL present captured word MSB-first on ser_bit, one bit per cycle, for exactly WIDTH cycles, then go REPORT.
REQ-021 Detector SHALL be a Mealy 1010 detector, states S0..S3: S0 1->S1 0->S0; S1 1->S1 0->S2; S2 1->S3 0->S0; S3 1->S1 0->S0 with match.
REQ-022 Match SHALL be non-overlapping: after a match detector returns to S0.
REQ-023 Each match SHALL increment count on that edge; count SHALL saturate at 2^CNT_W-1.
REQ-024 REPORT: done=1 for exactly one cycle with match_cnt and done_id valid; next state IDLE.
REQ-025 match_cnt and done_id SHALL hold last result until next grant clears count.
REQ-026 Latency: grant cycle g; SHIFT cycles g+1..g+WIDTH; done at g+WIDTH+1; earliest next grant g+WIDTH+2.
REQ-027 Detector state SHALL not carry between words.

Reset
REQ-028 reset SHALL force IDLE, detector S0, count 0, shift register 0, bit index WIDTH-1, rr pointer to "1 served last".
REQ-029 During and after reset: gnt0=gnt1=busy=ser_bit=done=done_id=0, match_cnt=0.
REQ-030 reset mid-SHIFT or REPORT SHALL abort; no done for aborted word; aborted requester not re-granted unless it re-requests.
REQ-031 reset SHALL override any simultaneous request; no gnt in reset cycle.

Verification
REQ-032 req0, din0=8'b10101010 -> gnt0 at g, ser_bit 1,0,1,0,1,0,1,0 over g+1..g+8, done at g+9, match_cnt=2, done_id=0.
REQ-033 req1 alone, din1=8'b11010100 -> gnt1, done at g+9, match_cnt=1, done_id=1.
REQ-034 req0 and req1 high from reset release -> gnt0 first, gnt1 at g+10, two done pulses, done_id 0 then 1.
REQ-035 din0=8'h00 then 8'hFF -> match_cnt=0 each; busy high exactly 9 cycles per word.
REQ-036 reset asserted at g+4 of a scan -> no done, all outputs 0 next cycle; then req0 and req1 both high -> gnt0 first.
REQ-037 WIDTH=16, CNT_W=2, din0=16'hAAAA -> 4 matches saturate, match_cnt=3 at done (g+17).
